// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared state type, sizing constants and onehot helper for the round-robin mux arbiter
package mux_arb_pkg;
  localparam int N_REQ = 4;
  localparam int SEL_W = 2;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic logic [N_REQ-1:0] to_onehot(input logic [SEL_W-1:0] i);
    return N_REQ'(1) << i;
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational 4-way round-robin picker, first set request at or after start
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);
  logic [N_REQ-1:0] w_rot;
  logic [SEL_W-1:0] w_off;
  // rotate so that bit 0 is the requester at start, then a fixed priority scan
  assign w_rot  = N_REQ'({req, req} >> start);
  assign w_off  = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3;
  assign found  = |req;
  assign idx    = start + w_off;
  assign onehot = found ? to_onehot(idx) : '0;
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner scheduling for a shared 4:1 mux with hold limit
// and a registered data output one cycle behind the grant.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int DW       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [4*DW-1:0]   d_in,
  output logic [3:0]        gnt,
  output logic [1:0]        sel,
  output logic              busy,
  output logic [DW-1:0]     y,
  output logic              y_valid
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  state_t           r_state, w_state_n;
  logic [N_REQ-1:0] r_gnt, w_gnt_n, w_onehot;
  logic [SEL_W-1:0] r_sel, w_sel_n, r_ptr, w_ptr_n, w_start, w_idx;
  logic [HW-1:0]    r_hold, w_hold_n;
  logic [DW-1:0]    r_y;
  logic             r_yv, w_found, w_rearb;
  // the owner is the current sel; rotation starts just past it so it is checked last
  assign w_rearb = !req[r_sel] || r_hold == HW'(MAX_HOLD);
  assign w_start = r_state == IDLE ? r_ptr : r_sel + 1'b1;
  rr_pick4 u_pick (
    .req    (req),
    .start  (w_start),
    .found  (w_found),
    .idx    (w_idx),
    .onehot (w_onehot)
  );
  always_comb begin
    w_state_n = r_state;
    w_gnt_n   = r_gnt;
    w_sel_n   = r_sel;
    w_ptr_n   = r_ptr;
    w_hold_n  = r_hold;
    if (r_state == IDLE) begin
      if (w_found) begin
        w_state_n = GRANT;
        w_gnt_n   = w_onehot;
        w_sel_n   = w_idx;
        w_hold_n  = HW'(1);
      end
    end else if (!w_rearb) begin
      w_hold_n = r_hold + 1'b1;
    end else begin
      w_ptr_n   = w_start;
      w_state_n = w_found ? GRANT : IDLE;
      w_gnt_n   = w_onehot;
      w_sel_n   = w_found ? w_idx : r_sel;
      w_hold_n  = w_found ? HW'(1) : '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
      r_y     <= '0;
      r_yv    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_gnt   <= w_gnt_n;
      r_sel   <= w_sel_n;
      r_ptr   <= w_ptr_n;
      r_hold  <= w_hold_n;
      r_yv    <= |r_gnt;
      if (|r_gnt) r_y <= d_in[r_sel*DW +: DW];
    end
  end
  assign gnt     = r_gnt;
  assign sel     = r_sel;
  assign busy    = |r_gnt;
  assign y       = r_y;
  assign y_valid = r_yv;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: vector table, directed corner sequences and random traffic against a reference model
module tb_mux4_rr_arbiter;
  localparam int DW = 1;
  localparam int MAXH = 8;
  logic clk = 0;
  logic rst_n = 0;
  logic [3:0] req = '0;
  logic [4*DW-1:0] d_in = '0;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic busy, y_valid;
  logic [DW-1:0] y;
  int checks = 0;
  int failures = 0;
  int m_owner = -1, m_cnt = 0, m_ptr = 0, m_sel = 0;
  logic [DW-1:0] m_y = '0;
  logic m_yv = 1'b0;
  typedef struct {
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       yv;
    logic       y;
  } vec_t;
  vec_t tv[10];

  mux4_rr_arbiter #(.MAX_HOLD(MAXH), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .d_in(d_in),
    .gnt(gnt), .sel(sel), .busy(busy), .y(y), .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int first_from(input logic [3:0] r, input int s);
    for (int k = 0; k < 4; k++) if (r[(s + k) % 4]) return (s + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_ptr = 0; m_sel = 0; m_y = '0; m_yv = 1'b0;
  endtask

  // one clock edge of the arbitration rules, with ownership tracked as an integer index
  task automatic model_edge();
    logic [DW-1:0] ny = m_y;
    logic nyv = (m_owner >= 0);
    if (m_owner >= 0) ny = d_in[m_sel*DW +: DW];
    if (m_owner < 0) begin
      int p = first_from(req, m_ptr);
      if (p >= 0) begin m_owner = p; m_sel = p; m_cnt = 1; end
    end else if (req[m_owner] && m_cnt < MAXH) begin
      m_cnt++;
    end else begin
      m_ptr = (m_owner + 1) % 4;
      m_owner = first_from(req, m_ptr);
      if (m_owner >= 0) begin m_sel = m_owner; m_cnt = 1; end
    end
    m_y = ny;
    m_yv = nyv;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".gnt"}, gnt, m_owner < 0 ? 0 : (1 << m_owner));
    chk({tag, ".sel"}, sel, m_sel);
    chk({tag, ".busy"}, busy, m_owner >= 0);
    chk({tag, ".y_valid"}, y_valid, m_yv);
    chk({tag, ".y"}, y, m_y);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; req = '0; d_in = '0;
    #1 model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    tv[0] = '{4'b0100, 4'b1011, 4'b0100, 2'd2, 1'b0, 1'b0};
    tv[1] = '{4'b0100, 4'b1011, 4'b0100, 2'd2, 1'b1, 1'b0};
    tv[2] = '{4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b1};
    tv[3] = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b1};
    tv[4] = '{4'b1010, 4'b0000, 4'b1000, 2'd3, 1'b0, 1'b1};
    tv[5] = '{4'b0010, 4'b1000, 4'b0010, 2'd1, 1'b1, 1'b1};
    tv[6] = '{4'b0011, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};
    tv[7] = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
    tv[8] = '{4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b1};
    tv[9] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1};
    #12;
    chk("rst.gnt", gnt, 0);
    chk("rst.sel", sel, 0);
    chk("rst.busy", busy, 0);
    chk("rst.y", y, 0);
    chk("rst.y_valid", y_valid, 0);
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      req = tv[i].req; d_in = tv[i].d;
      tick();
      chk($sformatf("vec%0d.gnt", i), gnt, tv[i].gnt);
      chk($sformatf("vec%0d.sel", i), sel, tv[i].sel);
      chk($sformatf("vec%0d.y_valid", i), y_valid, tv[i].yv);
      chk($sformatf("vec%0d.y", i), y, tv[i].y);
    end
    do_reset();
    req = 4'hF;
    for (int n = 0; n < 33; n++) begin
      tick();
      chk($sformatf("contend%0d.gnt", n), gnt, 1 << ((n / 8) % 4));
    end
    for (int n = 0; n < 8; n++) tick();
    chk("midgrant.gnt", gnt, 4'b0010);
    #2 rst_n = 0;
    #1;
    chk("async_rst.gnt", gnt, 0);
    chk("async_rst.sel", sel, 0);
    chk("async_rst.y_valid", y_valid, 0);
    chk("async_rst.busy", busy, 0);
    chk("async_rst.y", y, 0);
    model_reset();
    req = 4'b0100;
    @(negedge clk);
    rst_n = 1;
    tick();
    chk("post_rst.gnt", gnt, 4'b0100);
    chk("post_rst.sel", sel, 2'd2);
    do_reset();
    req = 4'b0101;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("early.own0", gnt, 4'b0001);
    end
    req = 4'b0100;
    tick();
    chk("early.switch", gnt, 4'b0100);
    req = 4'b0101;
    for (int n = 0; n < 7; n++) begin
      tick();
      chk($sformatf("early.hold%0d", n), gnt, 4'b0100);
    end
    tick();
    chk("early.rotate", gnt, 4'b0001);
    do_reset();
    req = 4'b0010;
    for (int n = 0; n < 20; n++) begin
      tick();
      chk($sformatf("lone%0d.gnt", n), gnt, 4'b0010);
      chk($sformatf("lone%0d.busy", n), busy, 1);
    end
    req = 4'b0000;
    tick();
    chk("idle.gnt", gnt, 0);
    chk("idle.sel", sel, 2'd1);
    cmp_model("idle1");
    tick();
    cmp_model("idle2");
    chk("idle.y_valid", y_valid, 0);
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      d_in = 4'($urandom);
      tick();
      cmp_model("rnd");
      chk("rnd.onehot0", $onehot0(gnt), 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
